// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// sign-extender/next-PC/write-data select codes and the registered decode bundle.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_U = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_IMM = 2'b01;
    localparam logic [1:0] NPC_ALU = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;
    localparam logic [1:0] WD_EXT = 2'b11;

    typedef struct packed {
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic [2:0] ext_op;
        logic       alua_sel;
        logic       alub_sel;
        logic [3:0] alu_op;
        logic       rf_we;    // already qualified by rd != x0
        logic [1:0] wd_sel;
        logic [1:0] npc_op;   // next-PC source used in WB
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: instruction word -> control bundle plus an
// illegal-opcode flag. The FSM registers the result while in DECODE.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  inst,
    output ctrl_bundle_t bundle,
    output logic         illegal
);

    logic       rd_nz;
    logic [2:0] f3;
    logic       unused_bits;

    assign rd_nz       = (inst[11:7] != 5'd0);
    assign f3          = inst[14:12];
    assign unused_bits = ^{inst[31], inst[29:15]};

    always_comb begin
        bundle  = '0;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_OP: begin
                bundle.alu_op = {inst[30], f3};
                bundle.rf_we  = rd_nz;
            end
            OPC_OP_IMM: begin
                // bit 30 is part of the immediate except for SRAI
                bundle.alub_sel = 1'b1;
                bundle.alu_op   = {(f3 == 3'b101) & inst[30], f3};
                bundle.rf_we    = rd_nz;
            end
            OPC_LOAD: begin
                bundle.is_load  = 1'b1;
                bundle.alub_sel = 1'b1;
                bundle.rf_we    = rd_nz;
                bundle.wd_sel   = WD_MEM;
            end
            OPC_STORE: begin
                bundle.is_store = 1'b1;
                bundle.ext_op   = EXT_S;
                bundle.alub_sel = 1'b1;
            end
            OPC_BRANCH: begin
                bundle.is_branch = 1'b1;
                bundle.ext_op    = EXT_B;
            end
            OPC_LUI: begin
                bundle.ext_op   = EXT_U;
                bundle.alub_sel = 1'b1;
                bundle.rf_we    = rd_nz;
                bundle.wd_sel   = WD_EXT;
            end
            OPC_AUIPC: begin
                bundle.ext_op   = EXT_U;
                bundle.alua_sel = 1'b1;
                bundle.alub_sel = 1'b1;
                bundle.rf_we    = rd_nz;
            end
            OPC_JAL: begin
                bundle.ext_op   = EXT_J;
                bundle.alua_sel = 1'b1;
                bundle.alub_sel = 1'b1;
                bundle.rf_we    = rd_nz;
                bundle.wd_sel   = WD_PC4;
                bundle.npc_op   = NPC_IMM;
            end
            OPC_JALR: begin
                bundle.alub_sel = 1'b1;
                bundle.rf_we    = rd_nz;
                bundle.wd_sel   = WD_PC4;
                bundle.npc_op   = NPC_ALU;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch handshake, decode bundle,
// EXEC/MEM/WB sequencing, ack timeout and sticky error flags.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned EXT_OP_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    input  logic                branch_taken,
    output logic                imem_req,
    output logic                ir_we,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                pc_we,
    output logic [1:0]          npc_op,
    output logic [EXT_OP_W-1:0] ext_op,
    output logic                alua_sel,
    output logic                alub_sel,
    output logic [3:0]          alu_op,
    output logic                rf_we,
    output logic [1:0]          wd_sel,
    output logic                illegal,
    output logic                bus_err,
    output logic [2:0]          state
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [2:0]       state_q, state_d;
    ctrl_bundle_t     bundle_q, bundle_d, dec_bundle;
    logic             dec_illegal;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout, waiting;

    ctrl_decode u_decode (
        .inst    (inst),
        .bundle  (dec_bundle),
        .illegal (dec_illegal)
    );

    assign timeout = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    assign waiting = ((state_q == ST_FETCH) && !imem_ack) || ((state_q == ST_MEM) && !dmem_ack);

    always_comb begin
        state_d   = state_q;
        bundle_d  = bundle_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    bundle_d = dec_bundle;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bundle_q.is_branch) begin
                    state_d = ST_FETCH;
                end else if (bundle_q.is_load || bundle_q.is_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = bundle_q.is_load ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        // Any state change restarts the wait count, which covers entry to FETCH and MEM.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            bundle_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bundle_q  <= bundle_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs are forced low during reset so an outstanding request is dropped at once.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        npc_op   = NPC_PC4;
        ext_op   = '0;
        alua_sel = 1'b0;
        alub_sel = 1'b0;
        alu_op   = 4'b0000;
        rf_we    = 1'b0;
        wd_sel   = WD_ALU;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        if (!rst) begin
            ext_op  = EXT_OP_W'(bundle_q.ext_op);
            wd_sel  = bundle_q.wd_sel;
            illegal = illegal_q;
            bus_err = bus_err_q;
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                alua_sel = bundle_q.alua_sel;
                alub_sel = bundle_q.alub_sel;
                alu_op   = bundle_q.alu_op;
            end
            case (state_q)
                ST_FETCH: imem_req = 1'b1;
                ST_EXEC: begin
                    if (bundle_q.is_branch) begin
                        pc_we  = 1'b1;
                        npc_op = branch_taken ? NPC_IMM : NPC_PC4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = bundle_q.is_store;
                    pc_we    = bundle_q.is_store & dmem_ack;
                end
                ST_WB: begin
                    rf_we  = bundle_q.rf_we;
                    pc_we  = 1'b1;
                    npc_op = bundle_q.npc_op;
                end
                default: ;
            endcase
        end
        ir_we = imem_req & imem_ack;
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: inputs change and outputs are
// sampled around the falling edge, away from the rising edge that moves the FSM.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        imem_ack, dmem_ack, branch_taken;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we;
    logic [1:0]  npc_op, wd_sel;
    logic [2:0]  ext_op, state;
    logic        alua_sel, alub_sel, illegal, bus_err;
    logic [3:0]  alu_op;

    int checks = 0;
    int errors = 0;

    // {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}
    logic [5:0]  en;
    logic [20:0] all_out;
    assign en      = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we};
    assign all_out = {en, npc_op, ext_op, alua_sel, alub_sel, alu_op, wd_sel, illegal, bus_err};

    multicycle_ctrl #(
        .ACK_TIMEOUT (16),
        .EXT_OP_W    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .pc_we        (pc_we),
        .npc_op       (npc_op),
        .ext_op       (ext_op),
        .alua_sel     (alua_sel),
        .alub_sel     (alub_sel),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wd_sel       (wd_sel),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; inst = 32'h0;
        step(); step();
        #1;
        checks++;
        if ({state, all_out} !== 24'h0) begin
            errors++;
            $display("FAIL reset_hold: state/outs got %0d/%h want 0/000000", state, all_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, en} !== {3'd0, 6'b100000}) begin
            errors++;
            $display("FAIL reset_release: state/en got %0d/%b want 0/100000", state, en);
        end
    endtask

    // Fetch with a zero-wait ack; leaves the bench in the DECODE cycle.
    task automatic fetch(input logic [31:0] word);
        inst = word; imem_ack = 1'b1;
        #1;
        checks++;
        if ({state, en} !== {3'd0, 6'b110000}) begin
            errors++;
            $display("FAIL fetch_%h: state/en got %0d/%b want 0/110000", word, state, en);
        end
        step();
        imem_ack = 1'b0;
    endtask

    task automatic test_addi;
        fetch(32'h00500093);
        #1;
        checks++;
        if ({state, en} !== {3'd1, 6'b000000}) begin
            errors++;
            $display("FAIL addi_decode: state/en got %0d/%b want 1/000000", state, en);
        end
        step(); #1;
        checks++;
        if ({state, en, ext_op, alua_sel, alub_sel, alu_op} !== {3'd2, 6'b0, 3'b000, 1'b0, 1'b1, 4'b0}) begin
            errors++;
            $display("FAIL addi_exec: state/en/ext/a/b/op got %0d/%b/%b/%b/%b/%b want 2/000000/000/0/1/0000",
                     state, en, ext_op, alua_sel, alub_sel, alu_op);
        end
        step(); #1;
        checks++;
        if ({state, en, wd_sel, npc_op} !== {3'd4, 6'b000011, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL addi_wb: state/en/wd/npc got %0d/%b/%b/%b want 4/000011/00/00",
                     state, en, wd_sel, npc_op);
        end
        step(); #1;
        checks++;
        if ({state, en} !== {3'd0, 6'b100000}) begin
            errors++;
            $display("FAIL addi_back: state/en got %0d/%b want 0/100000", state, en);
        end
    endtask

    task automatic test_alu_op;
        logic [31:0] words [2] = '{32'h402081B3, 32'h4030D093};  // sub x3,x1,x2 ; srai x1,x1,3
        logic [3:0]  ops   [2] = '{4'b1000, 4'b1101};
        logic        bsel  [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            fetch(words[i]);
            step(); #1;
            checks++;
            if ({state, alu_op, alub_sel} !== {3'd2, ops[i], bsel[i]}) begin
                errors++;
                $display("FAIL aluop_%0d: state/op/b got %0d/%b/%b want 2/%b/%b",
                         i, state, alu_op, alub_sel, ops[i], bsel[i]);
            end
            step(); step();
        end
    endtask

    task automatic test_branch;
        logic [1:0] want_npc [2] = '{2'b01, 2'b00};
        for (int i = 0; i < 2; i++) begin
            fetch(32'hFE208EE3);
            step();
            branch_taken = (i == 0);
            #1;
            checks++;
            if ({state, en, npc_op, ext_op} !== {3'd2, 6'b000010, want_npc[i], 3'b010}) begin
                errors++;
                $display("FAIL branch_exec_%0d: state/en/npc/ext got %0d/%b/%b/%b want 2/000010/%b/010",
                         i, state, en, npc_op, ext_op, want_npc[i]);
            end
            step();
            branch_taken = 1'b0;
            #1;
            checks++;
            if ({state, en} !== {3'd0, 6'b100000}) begin
                errors++;
                $display("FAIL branch_back_%0d: state/en got %0d/%b want 0/100000", i, state, en);
            end
        end
    endtask

    task automatic test_load_store;
        fetch(32'h0000A103);  // lw x2,0(x1)
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            dmem_ack = (i == 3);
            #1;
            checks++;
            if ({state, en} !== {3'd3, 6'b001000}) begin
                errors++;
                $display("FAIL lw_mem_%0d: state/en got %0d/%b want 3/001000", i, state, en);
            end
        end
        step();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if ({state, en, wd_sel} !== {3'd4, 6'b000011, 2'b01}) begin
            errors++;
            $display("FAIL lw_wb: state/en/wd got %0d/%b/%b want 4/000011/01", state, en, wd_sel);
        end
        step();
        fetch(32'h0020A223);  // sw x2,4(x1)
        step(); #1;
        checks++;
        if ({state, ext_op, alub_sel} !== {3'd2, 3'b001, 1'b1}) begin
            errors++;
            $display("FAIL sw_exec: state/ext/b got %0d/%b/%b want 2/001/1", state, ext_op, alub_sel);
        end
        step();
        dmem_ack = 1'b1;
        #1;
        checks++;
        if ({state, en, npc_op} !== {3'd3, 6'b001110, 2'b00}) begin
            errors++;
            $display("FAIL sw_mem: state/en/npc got %0d/%b/%b want 3/001110/00", state, en, npc_op);
        end
        step();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if ({state, en} !== {3'd0, 6'b100000}) begin
            errors++;
            $display("FAIL sw_back: state/en got %0d/%b want 0/100000", state, en);
        end
    endtask

    task automatic test_lui_jal;
        fetch(32'h00001037);  // lui x0,1
        step(); step(); #1;
        checks++;
        if ({state, en, wd_sel} !== {3'd4, 6'b000010, 2'b11}) begin
            errors++;
            $display("FAIL lui_wb: state/en/wd got %0d/%b/%b want 4/000010/11", state, en, wd_sel);
        end
        step();
        fetch(32'h008000EF);  // jal x1,8
        step(); #1;
        checks++;
        if ({state, en, ext_op} !== {3'd2, 6'b000000, 3'b100}) begin
            errors++;
            $display("FAIL jal_exec: state/en/ext got %0d/%b/%b want 2/000000/100", state, en, ext_op);
        end
        step(); #1;
        checks++;
        if ({state, en, wd_sel, npc_op} !== {3'd4, 6'b000011, 2'b10, 2'b01}) begin
            errors++;
            $display("FAIL jal_wb: state/en/wd/npc got %0d/%b/%b/%b want 4/000011/10/01",
                     state, en, wd_sel, npc_op);
        end
        step();
    endtask

    task automatic test_illegal;
        fetch(32'h0000007F);
        step(); #1;
        checks++;
        if ({state, en, illegal} !== {3'd5, 6'b000000, 1'b1}) begin
            errors++;
            $display("FAIL illegal_halt: state/en/ill got %0d/%b/%b want 5/000000/1", state, en, illegal);
        end
        imem_ack = 1'b1; dmem_ack = 1'b1;
        step(); step(); #1;
        checks++;
        if ({state, en, illegal} !== {3'd5, 6'b000000, 1'b1}) begin
            errors++;
            $display("FAIL illegal_stuck: state/en/ill got %0d/%b/%b want 5/000000/1", state, en, illegal);
        end
    endtask

    task automatic test_timeout;
        imem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({state, imem_req, bus_err} !== {3'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL timeout_wait_%0d: state/req/err got %0d/%b/%b want 0/1/0",
                         i, state, imem_req, bus_err);
            end
            step();
        end
        #1;
        checks++;
        if ({state, en, bus_err} !== {3'd5, 6'b000000, 1'b1}) begin
            errors++;
            $display("FAIL timeout_halt: state/en/err got %0d/%b/%b want 5/000000/1", state, en, bus_err);
        end
        imem_ack = 1'b1;
        step(); step(); #1;
        checks++;
        if ({state, en, bus_err} !== {3'd5, 6'b000000, 1'b1}) begin
            errors++;
            $display("FAIL timeout_stuck: state/en/err got %0d/%b/%b want 5/000000/1", state, en, bus_err);
        end
    endtask

    task automatic test_reset_mid_mem;
        fetch(32'h0000A103);
        step(); step();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if ({state, dmem_req} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL midmem_pre: state/dreq got %0d/%b want 3/1", state, dmem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_out !== 21'h0) begin
            errors++;
            $display("FAIL midmem_rst_same: outs got %h want 000000", all_out);
        end
        step(); #1;
        checks++;
        if ({state, all_out} !== 24'h0) begin
            errors++;
            $display("FAIL midmem_rst_next: state/outs got %0d/%h want 0/000000", state, all_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({state, en, illegal, bus_err} !== {3'd0, 6'b100000, 2'b00}) begin
            errors++;
            $display("FAIL midmem_release: state/en/flags got %0d/%b/%b%b want 0/100000/00",
                     state, en, illegal, bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_op();
        test_branch();
        test_load_store();
        test_lui_jal();
        test_illegal();
        test_reset();
        test_timeout();
        test_reset();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
